vga_layer_compositor: RTL
=========================

# vga_layer_compositor

Parametrised VGA timing generator with an N-layer rectangular-window compositor and a fixed two-cycle pixel pipeline. It produces horizontal and vertical counters, sync pulses of configurable polarity, and per-pixel RGB chosen by priority among up to NUM_LAYERS masked windows over a background colour. It drives the board VGA pins directly and feeds pixel coordinates to the sprite ROM and game-logic blocks upstream.

## Interface
- H_ACTIVE, 800, visible pixels per line
- H_FP / H_SYNC / H_BP, 56 / 120 / 64, horizontal porches and sync width in clocks (H_TOTAL = sum = 1040)
- V_ACTIVE, 600, visible lines per frame
- V_FP / V_SYNC / V_BP, 37 / 6 / 23, vertical porches and sync width in lines (V_TOTAL = sum = 666)
- HS_POL / VS_POL, 0 / 0, sync active level (0 = active-low pin)
- NUM_LAYERS, 3, compositor layers, 1..8
- COORD_W, 12, coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
- COLOR_W, 1, bits per colour channel
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-low reset
- win_x0, win_x1, win_y0, win_y1  in  NUM_LAYERS*COORD_W each  inclusive window bounds, layer i in bits [i*COORD_W +: COORD_W]
- layer_en  in  NUM_LAYERS  per-layer enable
- layer_mask  in  NUM_LAYERS  per-pixel opacity from sprite ROMs, one cycle after pix_x/pix_y
- layer_rgb  in  NUM_LAYERS*3*COLOR_W  per-layer colour {r,g,b}
- bg_rgb  in  3*COLOR_W  background colour inside the active area
- pix_x, pix_y  out  COORD_W  current horizontal and vertical counters (stage 0)
- frame_start, line_start  out  1  registered one-cycle strobes
- vga_r, vga_g, vga_b  out  COLOR_W  pixel colour
- vga_hs, vga_vs  out  1  sync pins

## Operation
- Stage 0 counters:
  - h_cnt counts 0..H_TOTAL-1, then wraps to 0.
  - v_cnt advances only on the h_cnt wrap and itself wraps after V_TOTAL-1.
  - pix_x = h_cnt, pix_y = v_cnt.
- Stage 1:
  - Register per-layer window hit for stage-0 coordinates: x0 ≤ x ≤ x1 and y0 ≤ y ≤ y1, unsigned.
  - If x0 > x1 or y0 > y1, the window is empty (never hits).
  - Register active = (h < H_ACTIVE && v < V_ACTIVE).
  - Register logical hs = h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; vs likewise on v_cnt.
- Stage 2:
  - Opaque layer i = hit1[i] & layer_mask[i] & en[i].
  - Lowest-index opaque layer wins; its layer_rgb is registered to the outputs.
  - If no layer is opaque, bg_rgb is output.
  - If active1 = 0, the output is all zeros (blanking overrides every layer).
  - hs/vs are registered and then driven to the pins as XNOR with HS_POL/VS_POL, so the pin equals the POL value while the pulse is asserted.
- frame_start is 1 in the cycle after h_cnt = 0, v_cnt = 0. line_start is 1 in the cycle after h_cnt = 0.
- Reset values:
  - counters 0; all pipeline registers 0
  - vga_r/g/b = 0
  - vga_hs = ~HS_POL, vga_vs = ~VS_POL
  - frame_start = 0, line_start = 0
- Reset mid-frame restarts both counters at 0 with the pipeline flushed. The first frame_start occurs 1 cycle after reset release.

## Timing
- Latency pix_x/pix_y → vga_* pixel, hs and vs: exactly 2 clocks. Sync stays aligned with colour.
- layer_mask is sampled at stage 1. The source must present the mask for coordinate (pix_x, pix_y) exactly one clock later, which matches a synchronous ROM.
- Frame period is H_TOTAL*V_TOTAL clocks, 692,640 at default parameters. Line period is H_TOTAL clocks.
- win_*, layer_en, layer_rgb and bg_rgb are sampled every clock unless shadowing is enabled. layer_rgb and bg_rgb are sampled at stage 2 and are never shadowed.

## Configuration
- VGA_SHADOW_LATCH_EN
- Defined:
  - win_x0/x1/y0/y1 and layer_en are copied into shadow registers on the last clock of each frame (h_cnt = H_TOTAL-1, v_cnt = V_TOTAL-1).
  - Stage 1 uses only the shadow copies, so window changes take effect from the next frame start. This prevents tearing.
  - Shadow reset value: coordinates 0, enables 0.
- Undefined:
  - Live inputs feed stage 1 directly, and changes take effect 1 clock later.

## Test plan
- Reset release, defaults, run 2 frames:
  - frame_start pulses exactly 692,640 clocks apart.
  - vga_hs is low for 120 clocks per line, starting at a 2-clock-delayed h = 856.
  - vga_vs is low for 6 lines starting at v = 637.
- HS_POL = 1, VS_POL = 1:
  - Idle pins are 0 after reset; pulses are high with identical widths.
- Priority overlap:
  - Layer 0 = red, window (100..199, 100..199); layer 1 = green, window (150..249, 150..249); masks 1, bg 0.
  - At pixel (160,160) the output is red.
  - At (220,220) the output is green.
  - At (50,50) the output is 0.
  - At (799,599) colour comes from bg; at (800,0) the output is 0 (blanking).
- Mask and empty window:
  - Layer 0 mask toggles every clock, aligned at +1 cycle; output alternates layer/bg per pixel.
  - Window x0 = 300 > x1 = 200 never hits.
- VGA_SHADOW_LATCH_EN:
  - Change win_x0 of layer 0 from 100 to 400 while v_cnt = 300.
  - Remaining lines of the current frame still use 100; the next frame uses 400.
  - Without the macro, line 301 uses 400.
- Reset asserted mid-line at (h = 500, v = 250):
  - Outputs immediately go to reset values.
  - After release, pix_x/pix_y count from 0 and frame_start appears 1 cycle after release.

Source files
------------

// File: rtl/vga_layer_compositor.sv
`default_nettype none
// ============================================================================
// Module   : vga_layer_compositor
// Purpose  : VGA timing generator with an N-layer priority window compositor
//            and a fixed two-clock pixel pipeline. Optional frame-boundary
//            shadowing of window bounds/enables via VGA_SHADOW_LATCH_EN.
// Revision : 1.0 - initial release
// ============================================================================
module vga_layer_compositor #(
  parameter int H_ACTIVE   = 800,
  parameter int H_FP       = 56,
  parameter int H_SYNC     = 120,
  parameter int H_BP       = 64,
  parameter int V_ACTIVE   = 600,
  parameter int V_FP       = 37,
  parameter int V_SYNC     = 6,
  parameter int V_BP       = 23,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int NUM_LAYERS = 3,
  parameter int COORD_W    = 12,
  parameter int COLOR_W    = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_LAYERS*COORD_W-1:0]     win_x0_i,
  input  logic [NUM_LAYERS*COORD_W-1:0]     win_x1_i,
  input  logic [NUM_LAYERS*COORD_W-1:0]     win_y0_i,
  input  logic [NUM_LAYERS*COORD_W-1:0]     win_y1_i,
  input  logic [NUM_LAYERS-1:0]             layer_en_i,
  input  logic [NUM_LAYERS-1:0]             layer_mask_i,
  input  logic [NUM_LAYERS*3*COLOR_W-1:0]   layer_rgb_i,
  input  logic [3*COLOR_W-1:0]              bg_rgb_i,
  output logic [COORD_W-1:0]                pix_x_o,
  output logic [COORD_W-1:0]                pix_y_o,
  output logic                              frame_start_o,
  output logic                              line_start_o,
  output logic [COLOR_W-1:0]                vga_r_o,
  output logic [COLOR_W-1:0]                vga_g_o,
  output logic [COLOR_W-1:0]                vga_b_o,
  output logic                              vga_hs_o,
  output logic                              vga_vs_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [COORD_W-1:0] H_LAST     = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST     = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ACT_END  = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT_END  = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_FIRST   = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_LAST    = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [COORD_W-1:0] VS_FIRST   = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_LAST    = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [COORD_W-1:0] COORD_ONE  = COORD_W'(1);

  // Stage 0: raster counters
  logic [COORD_W-1:0] h_q, h_d;
  logic [COORD_W-1:0] v_q, v_d;
  logic               h_wrap;

  always_comb begin
    h_wrap = (h_q == H_LAST);
    h_d    = h_wrap ? '0 : h_q + COORD_ONE;
    v_d    = v_q;
    if (h_wrap) begin
      v_d = (v_q == V_LAST) ? '0 : v_q + COORD_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign pix_x_o = h_q;
  assign pix_y_o = v_q;

  // Window bounds and enables seen by stage 1
  logic [NUM_LAYERS*COORD_W-1:0] x0_s, x1_s, y0_s, y1_s;
  logic [NUM_LAYERS-1:0]         en_s;

`ifdef VGA_SHADOW_LATCH_EN
  logic [NUM_LAYERS*COORD_W-1:0] x0_sh_q, x1_sh_q, y0_sh_q, y1_sh_q;
  logic [NUM_LAYERS-1:0]         en_sh_q;
  logic                          frame_last;

  assign frame_last = h_wrap && (v_q == V_LAST);

  // Copy on the last clock of a frame so a whole frame uses one set of windows
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x0_sh_q <= '0;
      x1_sh_q <= '0;
      y0_sh_q <= '0;
      y1_sh_q <= '0;
      en_sh_q <= '0;
    end else if (frame_last) begin
      x0_sh_q <= win_x0_i;
      x1_sh_q <= win_x1_i;
      y0_sh_q <= win_y0_i;
      y1_sh_q <= win_y1_i;
      en_sh_q <= layer_en_i;
    end
  end

  assign x0_s = x0_sh_q;
  assign x1_s = x1_sh_q;
  assign y0_s = y0_sh_q;
  assign y1_s = y1_sh_q;
  assign en_s = en_sh_q;
`else
  assign x0_s = win_x0_i;
  assign x1_s = win_x1_i;
  assign y0_s = win_y0_i;
  assign y1_s = win_y1_i;
  assign en_s = layer_en_i;
`endif

  // An inverted window (x0 > x1 or y0 > y1) can never satisfy both bounds
  logic [NUM_LAYERS-1:0] hit_d;

  for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_hit
    logic [COORD_W-1:0] wx0, wx1, wy0, wy1;
    assign wx0 = x0_s[gi*COORD_W +: COORD_W];
    assign wx1 = x1_s[gi*COORD_W +: COORD_W];
    assign wy0 = y0_s[gi*COORD_W +: COORD_W];
    assign wy1 = y1_s[gi*COORD_W +: COORD_W];
    assign hit_d[gi] = en_s[gi] && (wx0 <= h_q) && (h_q <= wx1) &&
                       (wy0 <= v_q) && (v_q <= wy1);
  end

  // Stage 1 registers
  logic [NUM_LAYERS-1:0] hit1_q;
  logic                  active1_q;
  logic                  hs1_q;
  logic                  vs1_q;
  logic                  frame_start_q;
  logic                  line_start_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit1_q        <= '0;
      active1_q     <= 1'b0;
      hs1_q         <= 1'b0;
      vs1_q         <= 1'b0;
      frame_start_q <= 1'b0;
      line_start_q  <= 1'b0;
    end else begin
      hit1_q        <= hit_d;
      active1_q     <= (h_q < H_ACT_END) && (v_q < V_ACT_END);
      hs1_q         <= (h_q >= HS_FIRST) && (h_q <= HS_LAST);
      vs1_q         <= (v_q >= VS_FIRST) && (v_q <= VS_LAST);
      frame_start_q <= (h_q == '0) && (v_q == '0);
      line_start_q  <= (h_q == '0);
    end
  end

  assign frame_start_o = frame_start_q;
  assign line_start_o  = line_start_q;

  // Stage 2: lowest-index opaque layer wins; blanking overrides everything
  logic [NUM_LAYERS-1:0]  opaque;
  logic [3*COLOR_W-1:0]   rgb_d;

  always_comb begin
    opaque = hit1_q & layer_mask_i;
    rgb_d  = bg_rgb_i;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (opaque[i]) begin
        rgb_d = layer_rgb_i[i*3*COLOR_W +: 3*COLOR_W];
      end
    end
    if (!active1_q) begin
      rgb_d = '0;
    end
  end

  logic [3*COLOR_W-1:0] rgb2_q;
  logic                 hs2_q;
  logic                 vs2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb2_q <= '0;
      hs2_q  <= 1'b0;
      vs2_q  <= 1'b0;
    end else begin
      rgb2_q <= rgb_d;
      hs2_q  <= hs1_q;
      vs2_q  <= vs1_q;
    end
  end

  assign vga_r_o  = rgb2_q[3*COLOR_W-1 -: COLOR_W];
  assign vga_g_o  = rgb2_q[2*COLOR_W-1 -: COLOR_W];
  assign vga_b_o  = rgb2_q[COLOR_W-1:0];
  assign vga_hs_o = hs2_q ~^ HS_POL;
  assign vga_vs_o = vs2_q ~^ VS_POL;

endmodule
`default_nettype wire
